mul_cyc_ctrl: RTL and testbench

MUL_CYC_CTRL -- requirements
Module: mul_cyc_ctrl

---
 rtl/mul_cyc_pkg.sv | 62 ++++++
 rtl/mul_cyc_dec.sv | 44 ++++
 rtl/mul_cyc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mul_cyc_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_cyc_pkg.sv
// ============================================================================
// Module  : mul_cyc_pkg
// Brief   : Shared encodings for the multi-cycle CPU controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_cyc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_HLT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CL_RTYPE,
    CL_ADDI,
    CL_ORI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_HALT,
    CL_ILL
  } iclass_t;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_ori   = 6'h0D;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_op_halt  = 6'h3F;

  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;
  localparam logic [5:0] c_fn_or  = 6'h25;
  localparam logic [5:0] c_fn_slt = 6'h2A;

  localparam logic [2:0] c_alu_add = 3'd0;
  localparam logic [2:0] c_alu_sub = 3'd1;
  localparam logic [2:0] c_alu_and = 3'd2;
  localparam logic [2:0] c_alu_or  = 3'd3;
  localparam logic [2:0] c_alu_slt = 3'd4;

  localparam logic [1:0] c_srcb_reg  = 2'd0;
  localparam logic [1:0] c_srcb_four = 2'd1;
  localparam logic [1:0] c_srcb_imm  = 2'd2;

  localparam logic [1:0] c_pc_plus4 = 2'd0;
  localparam logic [1:0] c_pc_br    = 2'd1;
  localparam logic [1:0] c_pc_jmp   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mul_cyc_dec.sv
// ============================================================================
// Module  : mul_cyc_dec
// Brief   : Combinational opcode/funct decoder to instruction class and aluOp.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_cyc_dec
  import mul_cyc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_fn,
  output iclass_t    o_cls,
  output logic [2:0] o_alu_op
);

  always_comb begin
    o_cls    = CL_ILL;
    o_alu_op = c_alu_add;
    case (i_op)
      c_op_rtype: begin
        case (i_fn)
          c_fn_add: begin o_cls = CL_RTYPE; o_alu_op = c_alu_add; end
          c_fn_sub: begin o_cls = CL_RTYPE; o_alu_op = c_alu_sub; end
          c_fn_and: begin o_cls = CL_RTYPE; o_alu_op = c_alu_and; end
          c_fn_or:  begin o_cls = CL_RTYPE; o_alu_op = c_alu_or;  end
          c_fn_slt: begin o_cls = CL_RTYPE; o_alu_op = c_alu_slt; end
          default:  o_cls = CL_ILL;
        endcase
      end
      c_op_addi: begin o_cls = CL_ADDI; o_alu_op = c_alu_add; end
      c_op_ori:  begin o_cls = CL_ORI;  o_alu_op = c_alu_or;  end
      c_op_lw:   begin o_cls = CL_LW;   o_alu_op = c_alu_add; end
      c_op_sw:   begin o_cls = CL_SW;   o_alu_op = c_alu_add; end
      c_op_beq:  begin o_cls = CL_BEQ;  o_alu_op = c_alu_sub; end
      c_op_j:    o_cls = CL_J;
      c_op_halt: o_cls = CL_HALT;
      default:   o_cls = CL_ILL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mul_cyc_ctrl.sv
// ============================================================================
// Module  : mul_cyc_ctrl
// Brief   : Multi-cycle CPU control FSM with retired-instruction counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_cyc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opCode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pcWr,
  output logic        irWr,
  output logic        memWr,
  output logic        memToReg,
  output logic        ifWR,
  output logic        wriReg,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  aluOp,
  output logic [1:0]  pcSrc,
  output logic [2:0]  stateOut,
  output logic        halt,
  output logic [15:0] insCnt
);

  import mul_cyc_pkg::*;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_op;
  logic [5:0]  r_fn;
  logic [15:0] r_ins_cnt;
  logic [5:0]  w_dec_op;
  logic [5:0]  w_dec_fn;
  iclass_t     w_cls;
  logic [2:0]  w_alu_op;
  logic        w_retire;

  logic        w_pc_wr, w_ir_wr, w_mem_wr, w_mem_to_reg, w_if_wr, w_wri_reg;
  logic [1:0]  w_src_b, w_pc_src;
  logic [2:0]  w_alu;

  // ID decodes the live IR fields; later states use the copy latched when leaving ID.
  assign w_dec_op = (r_state == S_ID) ? opCode : r_op;
  assign w_dec_fn = (r_state == S_ID) ? funct  : r_fn;

  mul_cyc_dec u_dec (
    .i_op     (w_dec_op),
    .i_fn     (w_dec_fn),
    .o_cls    (w_cls),
    .o_alu_op (w_alu_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= 6'd0;
      r_fn      <= 6'd0;
      r_ins_cnt <= 16'd0;
    end else begin
      if (r_state == S_ID) begin
        r_op <= opCode;
        r_fn <= funct;
      end
      if (w_retire) begin
        r_ins_cnt <= r_ins_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    w_pc_wr      = 1'b0;
    w_ir_wr      = 1'b0;
    w_mem_wr     = 1'b0;
    w_mem_to_reg = 1'b0;
    w_if_wr      = 1'b0;
    w_wri_reg    = 1'b0;
    w_src_b      = c_srcb_reg;
    w_pc_src     = c_pc_plus4;
    w_alu        = c_alu_add;
    case (r_state)
      S_IF: begin
        w_pc_wr  = 1'b1;
        w_ir_wr  = 1'b1;
        w_src_b  = c_srcb_four;
        w_pc_src = c_pc_plus4;
        w_next   = S_ID;
      end
      S_ID: begin
        case (w_cls)
          CL_J: begin
            w_pc_wr  = 1'b1;
            w_pc_src = c_pc_jmp;
            w_retire = 1'b1;
            w_next   = S_IF;
          end
          CL_HALT: w_next = S_HLT;
          CL_ILL:  w_next = S_IF;
          default: w_next = S_EXE;
        endcase
      end
      S_EXE: begin
        w_alu   = w_alu_op;
        w_src_b = (w_cls == CL_RTYPE || w_cls == CL_BEQ) ? c_srcb_reg : c_srcb_imm;
        case (w_cls)
          CL_BEQ: begin
            w_pc_wr  = zero;
            w_pc_src = c_pc_br;
            w_retire = 1'b1;
            w_next   = S_IF;
          end
          CL_LW, CL_SW:              w_next = S_MEM;
          CL_RTYPE, CL_ADDI, CL_ORI: w_next = S_WB;
          default:                   w_next = S_IF;
        endcase
      end
      S_MEM: begin
        if (w_cls == CL_SW) begin
          w_mem_wr = 1'b1;
          w_retire = 1'b1;
          w_next   = S_IF;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_if_wr      = 1'b1;
        w_wri_reg    = (w_cls != CL_RTYPE);
        w_mem_to_reg = (w_cls == CL_LW);
        w_retire     = 1'b1;
        w_next       = S_IF;
      end
      S_HLT:   w_next = S_HLT;
      default: w_next = S_IF;
    endcase
  end

  // Reset silences every strobe, even though the state already reads IF.
  assign pcWr     = w_pc_wr      & ~rst;
  assign irWr     = w_ir_wr      & ~rst;
  assign memWr    = w_mem_wr     & ~rst;
  assign memToReg = w_mem_to_reg & ~rst;
  assign ifWR     = w_if_wr      & ~rst;
  assign wriReg   = w_wri_reg    & ~rst;
  assign aluSrcB  = rst ? 2'd0 : w_src_b;
  assign aluOp    = rst ? 3'd0 : w_alu;
  assign pcSrc    = rst ? 2'd0 : w_pc_src;
  assign stateOut = r_state;
  assign halt     = (r_state == S_HLT);
  assign insCnt   = r_ins_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mul_cyc_ctrl.sv
// ============================================================================
// Module  : tb_mul_cyc_ctrl
// Brief   : Scoreboard bench for mul_cyc_ctrl with a per-instruction model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_cyc_ctrl;

  localparam int K_R = 0, K_ADDI = 1, K_ORI = 2, K_LW = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_J = 6, K_HALT = 7, K_ILL = 8;

  typedef struct packed {
    logic [2:0]  st;
    logic        pc_wr, ir_wr, mem_wr, mem_to_reg, if_wr, wri_reg;
    logic [1:0]  src_b;
    logic [2:0]  alu_op;
    logic [1:0]  pc_src;
    logic        hlt;
    logic [15:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opCode, funct;
  logic        zero;
  logic        pcWr, irWr, memWr, memToReg, ifWR, wriReg, halt;
  logic [1:0]  aluSrcB, pcSrc;
  logic [2:0]  aluOp, stateOut;
  logic [15:0] insCnt;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] model_cnt = 16'd0;
  obs_t        exp_q[$];
  obs_t        act, mon_e;

  always #5 clk = ~clk;

  mul_cyc_ctrl dut (
    .clk(clk), .rst(rst), .opCode(opCode), .funct(funct), .zero(zero),
    .pcWr(pcWr), .irWr(irWr), .memWr(memWr), .memToReg(memToReg),
    .ifWR(ifWR), .wriReg(wriReg), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSrc(pcSrc), .stateOut(stateOut), .halt(halt), .insCnt(insCnt)
  );

  always_comb act = {stateOut, pcWr, irWr, memWr, memToReg, ifWR, wriReg,
                     aluSrcB, aluOp, pcSrc, halt, insCnt};

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? K_R : K_ILL;
      6'h08:   return K_ADDI;
      6'h0D:   return K_ORI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      6'h3F:   return K_HALT;
      default: return K_ILL;
    endcase
  endfunction

  // Expected outputs for one cycle, straight from the instruction's behaviour table.
  function automatic obs_t expect_at(input int st, input int k, input logic [5:0] fn,
                                     input logic z, input logic [15:0] cnt);
    obs_t e;
    e = '0;
    e.st  = 3'(st);
    e.cnt = cnt;
    case (st)
      0: begin e.pc_wr = 1'b1; e.ir_wr = 1'b1; e.src_b = 2'd1; end
      1: if (k == K_J) begin e.pc_wr = 1'b1; e.pc_src = 2'd2; end
      2: begin
        e.src_b = (k == K_R || k == K_BEQ) ? 2'd0 : 2'd2;
        if (k == K_R)
          e.alu_op = (fn == 6'h22) ? 3'd1 : (fn == 6'h24) ? 3'd2 :
                     (fn == 6'h25) ? 3'd3 : (fn == 6'h2A) ? 3'd4 : 3'd0;
        else if (k == K_ORI) e.alu_op = 3'd3;
        else if (k == K_BEQ) e.alu_op = 3'd1;
        if (k == K_BEQ) begin e.pc_wr = z; e.pc_src = 2'd1; end
      end
      3: e.mem_wr = (k == K_SW);
      4: begin e.if_wr = 1'b1; e.wri_reg = (k != K_R); e.mem_to_reg = (k == K_LW); end
      7: e.hlt = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, output int n);
    int k;
    int path[$];
    k = classify(op, fn);
    path = {0, 1};
    case (k)
      K_R, K_ADDI, K_ORI: path = {path, 2, 4};
      K_LW:               path = {path, 2, 3, 4};
      K_SW:               path = {path, 2, 3};
      K_BEQ:              path = {path, 2};
      K_HALT:             for (int i = 0; i < 10; i++) path.push_back(7);
      default: ;
    endcase
    foreach (path[i]) exp_q.push_back(expect_at(path[i], k, fn, z, model_cnt));
    if (k != K_ILL && k != K_HALT) model_cnt = model_cnt + 16'd1;
    n = path.size();
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
    opCode = op; funct = fn; zero = z;
    @(posedge clk); #1;
    @(posedge clk); #1;
    opCode = 6'($urandom);
    funct  = 6'($urandom);
    for (int c = 2; c < n; c++) begin @(posedge clk); #1; end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int n;
    issue(op, fn, z, n);
    drive(op, fn, z, n);
  endtask

  task automatic do_reset_release();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 16'd0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check($sformatf("cycle%0d_state%0d", cyc, mon_e.st), act, mon_e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    int         n;
    logic [5:0] ops[7];
    logic [5:0] fns[5];
    ops = '{6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    rst = 1'b1; opCode = 6'd0; funct = 6'd0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", act, '0);
    rst = 1'b0;

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      if (op == 6'h3F) op = 6'h3E;
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, 1'($urandom_range(0, 1)));
    end

    run_instr(6'h00, 6'h20, 1'b0);
    run_instr(6'h08, 6'h00, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h2B, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0);
    run_instr(6'h3E, 6'h00, 1'b0);
    run_instr(6'h00, 6'h21, 1'b0);
    run_instr(6'h3F, 6'h00, 1'b0);

    rst = 1'b1;
    #1;
    check("rst_from_hlt", act, '0);
    do_reset_release();

    run_instr(6'h02, 6'h00, 1'b0);
    issue(6'h00, 6'h20, 1'b0, n);
    drive(6'h00, 6'h20, 1'b0, 3);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_in_wb", act, '0);
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_hold", act, '0);
    do_reset_release();

    for (int i = 0; i < 65535; i++) run_instr(6'h02, 6'h00, 1'b0);
    check("cnt_preload", 33'(insCnt), 33'(16'hFFFF));
    run_instr(6'h00, 6'h25, 1'b0);
    check("cnt_wrap", 33'(insCnt), 33'(16'h0000));
    run_instr(6'h02, 6'h00, 1'b0);
    @(negedge clk); #1;
    check("queue_drained", 33'(exp_q.size()), 33'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
